// File: rtl/cpu_pkg.sv
// Shared core package: RISC-V opcode constants, the immediate-select code
// consumed by decode and the immediate extender, and the fetch-queue entry.
package cpu_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_J    = 3'b011,
        IMM_U    = 3'b100,
        IMM_CSR  = 3'b101,
        IMM_NONE = 3'b111
    } imm_src_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        imm_src_t    imm_src;
        logic        is_ctrl;
    } fq_entry_t;

endpackage

// File: rtl/fq_predecode.sv
// Combinational predecoder applied to each instruction as it enters the
// fetch queue.
//   instr   : 32-bit instruction word
//   imm_src : immediate-select code for the extender
//   is_ctrl : instruction is BRANCH, JAL or JALR
module fq_predecode
    import cpu_pkg::*;
(
    input  logic [31:0] instr,
    output imm_src_t    imm_src,
    output logic        is_ctrl
);

    // Only the opcode and funct3[2] matter here.
    logic unused_bits;
    assign unused_bits = ^{instr[31:15], instr[13:7]};

    always_comb begin
        imm_src = IMM_NONE;
        is_ctrl = 1'b0;
        case (instr[6:0])
            OP_IMM, LOAD: imm_src = IMM_I;
            JALR: begin
                imm_src = IMM_I;
                is_ctrl = 1'b1;
            end
            STORE:        imm_src = IMM_S;
            BRANCH: begin
                imm_src = IMM_B;
                is_ctrl = 1'b1;
            end
            JAL: begin
                imm_src = IMM_J;
                is_ctrl = 1'b1;
            end
            LUI, AUIPC:   imm_src = IMM_U;
            // funct3[2] separates the CSR*I forms (zimm in rs1 field)
            // from the register forms and ECALL/EBREAK.
            SYSTEM:       imm_src = instr[14] ? IMM_CSR : IMM_I;
            default:      imm_src = IMM_NONE;
        endcase
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode. Stores {pc, instr,
// pred_taken} plus the predecoded immediate select and control-flow flag.
//   clk, rst_n        : clock, synchronous active-low reset
//   flush             : redirect; drops every entry and any push this cycle
//   in_valid/in_ready : fetch-side handshake with in_pc, in_instr,
//                       in_pred_taken
//   out_valid/out_ready : decode-side handshake; out_* show the head entry
//   count             : occupancy after the last edge
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     in_pred_taken,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_pred_taken,
    output logic [2:0]               out_imm_src,
    output logic                     out_is_ctrl,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    fq_entry_t       mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    imm_src_t        pd_imm;
    logic            pd_ctrl;
    fq_entry_t       head;

    fq_predecode u_predecode (
        .instr   (in_instr),
        .imm_src (pd_imm),
        .is_ctrl (pd_ctrl)
    );

    // Extra pointer MSB: equal low bits with differing MSB means full.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // Each ready/valid depends only on local state, flush and reset.
    assign in_ready  = !full && !flush && rst_n;
    assign out_valid = !empty && !flush && rst_n;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= '{pc:         in_pc,
                                       instr:      in_instr,
                                       pred_taken: in_pred_taken,
                                       imm_src:    pd_imm,
                                       is_ctrl:    pd_ctrl};
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    assign head = mem[rptr[AW-1:0]];

    // Outputs are forced to zero while reset is held.
    assign count          = rst_n ? (wptr - rptr) : '0;
    assign out_pc         = rst_n ? head.pc : 32'h0;
    assign out_instr      = rst_n ? head.instr : 32'h0;
    assign out_pred_taken = rst_n ? head.pred_taken : 1'b0;
    assign out_imm_src    = rst_n ? 3'(head.imm_src) : 3'b000;
    assign out_is_ctrl    = rst_n ? head.is_ctrl : 1'b0;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = 32'h0;
    logic [31:0] in_instr = 32'h0;
    logic        in_pred_taken = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_pred_taken;
    logic [2:0]  out_imm_src;
    logic        out_is_ctrl;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_instr       (in_instr),
        .in_pred_taken  (in_pred_taken),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_pred_taken (out_pred_taken),
        .out_imm_src    (out_imm_src),
        .out_is_ctrl    (out_is_ctrl),
        .count          (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered queue of accepted instructions.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } ent_t;
    ent_t q[$];
    logic exp_ir;
    logic exp_ov;

    function automatic logic [2:0] ref_imm(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03, 7'h67: return 3'b000;
            7'h23:               return 3'b001;
            7'h63:               return 3'b010;
            7'h6F:               return 3'b011;
            7'h37, 7'h17:        return 3'b100;
            7'h73:               return i[14] ? 3'b101 : 3'b000;
            default:             return 3'b111;
        endcase
    endfunction

    function automatic logic ref_ctrl(input logic [31:0] i);
        return (i[6:0] == 7'h63) || (i[6:0] == 7'h6F) || (i[6:0] == 7'h67);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply inputs for one cycle and compare all outputs to the model.
    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                         input logic pr, input logic ordy, input logic fl, input logic rs);
        in_valid = iv; in_pc = pc; in_instr = instr; in_pred_taken = pr;
        out_ready = ordy; flush = fl; rst_n = rs;
        #1;
        exp_ir = rs && !fl && (q.size() < DEPTH);
        exp_ov = rs && !fl && (q.size() > 0);
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("count", 32'(count), rs ? 32'(q.size()) : 32'h0);
        if (!rs) begin
            chk("rst_out_pc", out_pc, 32'h0);
            chk("rst_out_instr", out_instr, 32'h0);
            chk("rst_out_imm", 32'(out_imm_src), 32'h0);
            chk("rst_out_ctrl", 32'(out_is_ctrl), 32'h0);
            chk("rst_out_pred", 32'(out_pred_taken), 32'h0);
        end else if (exp_ov) begin
            chk("head_pc", out_pc, q[0].pc);
            chk("head_instr", out_instr, q[0].instr);
            chk("head_pred", 32'(out_pred_taken), 32'(q[0].pred));
            chk("head_imm", 32'(out_imm_src), 32'(ref_imm(q[0].instr)));
            chk("head_ctrl", 32'(out_is_ctrl), 32'(ref_ctrl(q[0].instr)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (out_ready && exp_ov) void'(q.pop_front());
            if (in_valid && exp_ir) q.push_back('{pc: in_pc, instr: in_instr, pred: in_pred_taken});
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 32'h0, 32'h0, 1'b0, ordy, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  imm;
        logic        ctrl;
    } vec_t;
    vec_t vec[12];

    logic [31:0] seq_instr[6];
    logic [2:0]  seq_imm[6];
    logic        seq_ctrl[6];
    logic [31:0] opc[10];

    initial begin
        vec[0]  = '{32'h00500093, 3'b000, 1'b0};  // addi
        vec[1]  = '{32'h00112623, 3'b001, 1'b0};  // sw
        vec[2]  = '{32'h00208463, 3'b010, 1'b1};  // beq
        vec[3]  = '{32'h008000EF, 3'b011, 1'b1};  // jal
        vec[4]  = '{32'h123450B7, 3'b100, 1'b0};  // lui
        vec[5]  = '{32'h00000097, 3'b100, 1'b0};  // auipc
        vec[6]  = '{32'h000080E7, 3'b000, 1'b1};  // jalr
        vec[7]  = '{32'h0000A083, 3'b000, 1'b0};  // lw
        vec[8]  = '{32'h3400D073, 3'b101, 1'b0};  // csrrwi
        vec[9]  = '{32'h34001073, 3'b000, 1'b0};  // csrrw
        vec[10] = '{32'h002081B3, 3'b111, 1'b0};  // add
        vec[11] = '{32'hFFFFFFFF, 3'b111, 1'b0};  // illegal

        seq_instr = '{32'h00112623, 32'h00208463, 32'h008000EF,
                      32'h123450B7, 32'h3400D073, 32'h002081B3};
        seq_imm   = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};
        seq_ctrl  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        opc = '{32'h13, 32'h03, 32'h67, 32'h23, 32'h63, 32'h6F, 32'h37, 32'h17, 32'h73, 32'h33};

        // Reset
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h0);
        tick();
        idle(1'b0);
        chk("post_reset_in_ready", 32'(in_ready), 32'h1);

        // Single addi push with decode ready
        drive(1'b1, 32'h0, 32'h00500093, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("no_empty_bypass", 32'(out_valid), 32'h0);
        tick();
        idle(1'b1);
        chk("addi_valid", 32'(out_valid), 32'h1);
        chk("addi_imm", 32'(out_imm_src), 32'h0);
        chk("addi_ctrl", 32'(out_is_ctrl), 32'h0);
        chk("addi_pc", out_pc, 32'h0);
        chk("addi_count", 32'(count), 32'h1);
        tick();
        idle(1'b1);
        chk("addi_count_after_pop", 32'(count), 32'h0);
        tick();

        // Predecode table
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), vec[i].instr, i[0], 1'b0, 1'b0, 1'b1);
            tick();
            idle(1'b1);
            chk("tbl_imm", 32'(out_imm_src), 32'(vec[i].imm));
            chk("tbl_ctrl", 32'(out_is_ctrl), 32'(vec[i].ctrl));
            tick();
        end

        // Fill with decode stalled, then release while fetch keeps offering
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), seq_instr[i], 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        begin
            int k;
            int idx;
            k = 0;
            idx = 4;
            drive(1'b1, 32'h210, seq_instr[4], 1'b0, 1'b1, 1'b0, 1'b1);
            chk("full_in_ready", 32'(in_ready), 32'h0);
            chk("full_count", 32'(count), 32'h4);
            chk("seq_imm", 32'(out_imm_src), 32'(seq_imm[0]));
            chk("seq_ctrl", 32'(out_is_ctrl), 32'(seq_ctrl[0]));
            k = 1;
            tick();
            for (int c = 0; c < 12 && k < 6; c++) begin
                logic iv;
                iv = (idx < 6);
                drive(iv, 32'h200 + 32'(idx * 4), iv ? seq_instr[idx] : 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
                if (c == 0) begin
                    chk("after_full_count", 32'(count), 32'h3);
                    chk("after_full_in_ready", 32'(in_ready), 32'h1);
                end
                if (out_valid) begin
                    chk("seq_imm", 32'(out_imm_src), 32'(seq_imm[k]));
                    chk("seq_ctrl", 32'(out_is_ctrl), 32'(seq_ctrl[k]));
                    k++;
                end
                if (iv && in_ready) idx++;
                tick();
            end
            chk("seq_all_out", 32'(k), 32'h6);
        end
        idle(1'b1);
        tick();

        // Half full, push and pop every cycle across pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), $urandom, 1'b1, 1'b0, 1'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h308 + 32'(i * 4), $urandom, 1'($urandom), 1'b1, 1'b0, 1'b1);
            chk("steady_count", 32'(count), 32'h2);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            tick();
        end

        // Flush with three entries queued and a push offered
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(i * 4), 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 32'hDEAD0000, 32'h00000013, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        chk("flush_in_ready", 32'(in_ready), 32'h0);
        tick();
        idle(1'b1);
        chk("post_flush_count", 32'(count), 32'h0);
        chk("post_flush_out_valid", 32'(out_valid), 32'h0);
        chk("post_flush_in_ready", 32'(in_ready), 32'h1);
        tick();
        idle(1'b1);
        chk("dropped_not_seen", 32'(out_valid), 32'h0);
        tick();

        // Reset pulse with two entries held
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h500 + 32'(i * 4), 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_pulse_count", 32'(count), 32'h0);
        chk("rst_pulse_out_valid", 32'(out_valid), 32'h0);
        chk("rst_pulse_in_ready", 32'(in_ready), 32'h0);
        chk("rst_pulse_out_pc", out_pc, 32'h0);
        tick();
        idle(1'b0);
        chk("rst_release_in_ready", 32'(in_ready), 32'h1);
        chk("rst_release_out_valid", 32'(out_valid), 32'h0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(3) != 0) ins = {ins[31:7], opc[$urandom_range(9)][6:0]};
            drive(1'($urandom_range(3) != 0), $urandom, ins, 1'($urandom),
                  1'($urandom_range(2) != 0), 1'($urandom_range(19) == 0),
                  1'($urandom_range(99) != 0));
            tick();
        end
        idle(1'b1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
